reg_context_seq: RTL and testbench
==================================

# reg_context_seq

Context save/restore sequencer and access arbiter for the 8×8 register array. It sits between the control unit and the register array's control inputs (`RN_Reg_Sel`, `Control_in`, `S8`) and between the register array and data memory. When idle it passes control-unit commands straight through. On a save or restore request it takes ownership of the array, stalls the CPU, and walks R0..R7 to or from a fixed data-memory window.

## Interface
Parameters:
- `BASE_ADDR`, default 8'hF0: data-memory address of the saved R0. Rn is stored at `BASE_ADDR + n`, modulo 256.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `save_req`  in  1  request to copy R0..R7 to DM; sampled only in IDLE.
- `restore_req`  in  1  request to load R0..R7 from DM; sampled only in IDLE.
- `cpu_rn_sel`  in  3  control-unit register select.
- `cpu_ctrl`  in  2  control-unit load enables: bit1 = LRN, bit0 = LR0.
- `cpu_s8`  in  3  control-unit MUX8 select.
- `rn_data`  in  8  array RN output; combinational on `ra_rn_sel`.
- `ra_rn_sel`  out  3  to array `RN_Reg_Sel`.
- `ra_ctrl`  out  2  to array `Control_in`.
- `ra_s8`  out  3  to array `S8`.
- `dm_addr`  out  8  data-memory address.
- `dm_wdata`  out  8  data-memory write data.
- `dm_we`  out  1  data-memory write strobe.
- `dm_re`  out  1  data-memory read strobe. Read data reaches the array `DM_in` one cycle later.
- `ctx_busy`  out  1  high in SAVE, RESTORE and DONE.
- `ctx_done`  out  1  one-cycle pulse in DONE.
- `cpu_stall`  out  1  equals `ctx_busy`.

## Operation
- The FSM has four states: IDLE, SAVE, RESTORE, DONE. A 4-bit counter `cnt` runs alongside it.
- **IDLE**
  - `ra_*` = `cpu_*` (combinational pass-through).
  - `dm_we`, `dm_re` = 0; `dm_addr` = 0; `ctx_busy` = 0.
  - If `save_req`: go to SAVE with `cnt` = 0.
  - Else if `restore_req`: go to RESTORE with `cnt` = 0.
  - Save wins when both requests are high together.
- **SAVE** (`cnt` 0..7)
  - `ra_rn_sel` = `cnt`; `ra_ctrl` = 2'b00; `ra_s8` = 3'b000.
  - `dm_we` = 1; `dm_addr` = `BASE_ADDR + cnt`; `dm_wdata` = `rn_data`.
  - `cnt` increments each cycle. After `cnt` = 7, go to DONE.
- **RESTORE** (`cnt` 0..8), a pipelined read and write-back:
  - Reads: `dm_re` = 1 and `dm_addr` = `BASE_ADDR + cnt` while `cnt` ≤ 7.
  - Write-back while `cnt` ≥ 1: `ra_ctrl` = 2'b10 (LRN only), `ra_s8` = 3'b100 (DM source), `ra_rn_sel` = `cnt` − 1.
  - At `cnt` = 0: `ra_ctrl` = 00.
  - After `cnt` = 8, go to DONE.
- **DONE**
  - `ctx_done` = 1; `ra_ctrl` = 00; `dm_we` = `dm_re` = 0.
  - Next state is IDLE.
- Ownership: `cpu_*` inputs are ignored in every state except IDLE.
- Sequencing never emits `ra_ctrl` = 2'b11 (broadcast load). In IDLE, `cpu_ctrl` passes through unmodified.
- Address arithmetic: 8-bit and wraps modulo 256.
- Requests arriving while busy are dropped, not queued. A requester holds its request or retries after `ctx_busy` falls.

## Timing
- Reset:
  - While `rst` is high, `ra_ctrl` is forced to 00.
  - Next state is IDLE with `cnt` = 0.
  - `ctx_busy`, `ctx_done`, `cpu_stall`, `dm_we`, `dm_re` = 0; `dm_addr` = 0.
  - `ra_rn_sel` and `ra_s8` follow `cpu_*`.
- Latency: a request sampled at edge E puts the FSM in SAVE or RESTORE in the cycle after E.
  - Save: busy for 9 cycles (8 SAVE + 1 DONE).
  - Restore: busy for 10 cycles (9 RESTORE + 1 DONE).
  - Back in IDLE on the following cycle; a new request can be accepted there.
- DM read timing: address in cycle k, data on `DM_in` in cycle k+1. The array loads Rn at the end of cycle k+1.
- DM write and array load commit on the same edge the strobe is sampled.
- Reset mid-operation:
  - Transfers strobed in the cycle `rst` is sampled still commit.
  - No further strobes follow.
  - Registers and memory that were not yet touched keep their old values.
  - No `ctx_done` pulse is generated.

## Test plan
- Save, registers = 00..07, `BASE_ADDR` = F0:
  - DM[F0..F7] = 00..07.
  - `dm_we` high for exactly 8 cycles.
  - `ctx_busy` high for 9 cycles.
  - `ctx_done` pulses once, in the 9th busy cycle.
- Restore, DM[F0..F7] = A0..A7:
  - R0..R7 = A0..A7; `R0_out` = A0.
  - `ctx_busy` high for 10 cycles.
  - `ra_ctrl` is never 11 and never 01.
- `save_req` and `restore_req` asserted together in IDLE → a save runs and DM is written. The second request asserted during busy → ignored, and no restore follows.
- IDLE pass-through: `cpu_ctrl` = 01, `cpu_s8` = 001, ALU = 5A → R0 = 5A. During busy, `cpu_ctrl` = 11 → no broadcast, and `cpu_stall` = 1.
- `rst` asserted in the SAVE cycle with `cnt` = 4:
  - F0..F4 written; F5..F7 unchanged.
  - Next cycle is IDLE with `ctx_busy` = 0 and no `ctx_done`.
- `BASE_ADDR` = FC, save → addresses FC, FD, FE, FF, 00, 01, 02, 03, in that order.

Source files
------------

// File: rtl/reg_context_seq.sv
// Context save/restore sequencer: owns the 8x8 register array while it copies R0..R7 to
// or from a fixed data-memory window; otherwise passes control-unit commands through.
//  state     | meaning
//  S_IDLE    | cpu_* passes through to the array, waiting for a request
//  S_SAVE    | cnt 0..7: Rcnt -> DM[BASE+cnt]
//  S_RESTORE | cnt 0..8: read DM[BASE+cnt], write back R(cnt-1) from DM_in
//  S_DONE    | one-cycle completion pulse, still busy
module reg_context_seq #(
   parameter logic [7:0] BASE_ADDR = 8'hF0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       save_req,
   input  logic       restore_req,
   input  logic [2:0] cpu_rn_sel,
   input  logic [1:0] cpu_ctrl,
   input  logic [2:0] cpu_s8,
   input  logic [7:0] rn_data,
   output logic [2:0] ra_rn_sel,
   output logic [1:0] ra_ctrl,
   output logic [2:0] ra_s8,
   output logic [7:0] dm_addr,
   output logic [7:0] dm_wdata,
   output logic       dm_we,
   output logic       dm_re,
   output logic       ctx_busy,
   output logic       ctx_done,
   output logic       cpu_stall
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SAVE    = 2'd1,
      S_RESTORE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] cnt_m1;
   logic [7:0] win_addr;

   assign cnt_m1   = cnt_q - 4'd1;
   assign win_addr = BASE_ADDR + {5'b00000, cnt_q[2:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 4'd0;
            if (save_req)         state_d = S_SAVE;
            else if (restore_req) state_d = S_RESTORE;
         end
         S_SAVE: begin
            if (cnt_q == 4'd7) begin
               state_d = S_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESTORE: begin
            if (cnt_q == 4'd8) begin
               state_d = S_DONE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   always_comb begin
      ra_rn_sel = cpu_rn_sel;
      ra_ctrl   = cpu_ctrl;
      ra_s8     = cpu_s8;
      dm_addr   = 8'h00;
      dm_wdata  = rn_data;
      dm_we     = 1'b0;
      dm_re     = 1'b0;
      ctx_busy  = 1'b0;
      ctx_done  = 1'b0;
      case (state_q)
         S_IDLE: ;
         S_SAVE: begin
            ra_rn_sel = cnt_q[2:0];
            ra_ctrl   = 2'b00;
            ra_s8     = 3'b000;
            dm_we     = 1'b1;
            dm_addr   = win_addr;
            ctx_busy  = 1'b1;
         end
         S_RESTORE: begin
            ra_rn_sel = 3'd0;
            ra_ctrl   = 2'b00;
            ra_s8     = 3'b100;
            ctx_busy  = 1'b1;
            if (cnt_q <= 4'd7) begin
               dm_re   = 1'b1;
               dm_addr = win_addr;
            end
            // Write-back trails the read by one cycle to match DM read latency.
            if (cnt_q >= 4'd1) begin
               ra_ctrl   = 2'b10;
               ra_rn_sel = cnt_m1[2:0];
            end
         end
         S_DONE: begin
            ra_rn_sel = 3'd0;
            ra_ctrl   = 2'b00;
            ra_s8     = 3'b000;
            ctx_busy  = 1'b1;
            ctx_done  = 1'b1;
         end
         default: ;
      endcase
      if (rst) ra_ctrl = 2'b00;
   end

   assign cpu_stall = ctx_busy;

endmodule

// File: tb/tb_reg_context_seq.sv
// Bench for reg_context_seq: models the register array and data memory around the DUT and
// checks save/restore results against expected register/memory contents.
module tb_reg_context_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, save_req, restore_req, save_fc, zero_fc;
   logic [2:0] cpu_rn_sel, cpu_s8;
   logic [1:0] cpu_ctrl;
   logic [7:0] alu;

   logic [2:0] ra_rn_sel, ra_s8, ra_rn_sel_fc, ra_s8_fc;
   logic [1:0] ra_ctrl, ra_ctrl_fc;
   logic [7:0] dm_addr, dm_wdata, dm_addr_fc, dm_wdata_fc, rn_data, rn_data_fc;
   logic       dm_we, dm_re, ctx_busy, ctx_done, cpu_stall;
   logic       dm_we_fc, dm_re_fc, ctx_busy_fc, ctx_done_fc, cpu_stall_fc;

   logic [7:0] regs [8];
   logic [7:0] mem [256];
   logic [7:0] dm_in = 8'h00;
   logic [7:0] mux;

   int n_busy = 0, n_we = 0, n_re = 0, n_done = 0, n_bad = 0, run = 0, done_at = 0;
   logic [7:0] fc_addr_q[$];
   logic [7:0] fc_data_q[$];

   int vectors = 0;
   int miscompares = 0;

   reg_context_seq dut (
      .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
      .cpu_rn_sel(cpu_rn_sel), .cpu_ctrl(cpu_ctrl), .cpu_s8(cpu_s8), .rn_data(rn_data),
      .ra_rn_sel(ra_rn_sel), .ra_ctrl(ra_ctrl), .ra_s8(ra_s8),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_re(dm_re),
      .ctx_busy(ctx_busy), .ctx_done(ctx_done), .cpu_stall(cpu_stall)
   );

   reg_context_seq #(.BASE_ADDR(8'hFC)) dut_fc (
      .clk(clk), .rst(rst), .save_req(save_fc), .restore_req(zero_fc),
      .cpu_rn_sel(cpu_rn_sel), .cpu_ctrl(cpu_ctrl), .cpu_s8(cpu_s8), .rn_data(rn_data_fc),
      .ra_rn_sel(ra_rn_sel_fc), .ra_ctrl(ra_ctrl_fc), .ra_s8(ra_s8_fc),
      .dm_addr(dm_addr_fc), .dm_wdata(dm_wdata_fc), .dm_we(dm_we_fc), .dm_re(dm_re_fc),
      .ctx_busy(ctx_busy_fc), .ctx_done(ctx_done_fc), .cpu_stall(cpu_stall_fc)
   );

   assign rn_data    = regs[ra_rn_sel];
   assign rn_data_fc = regs[ra_rn_sel_fc];

   always_comb begin
      case (ra_s8)
         3'b001:  mux = alu;
         3'b100:  mux = dm_in;
         default: mux = 8'h00;
      endcase
   end

   // Register array, data memory and activity counters.
   always @(posedge clk) begin
      if (ra_ctrl[0]) regs[0] <= mux;
      if (ra_ctrl[1]) regs[ra_rn_sel] <= mux;
      if (dm_we) mem[dm_addr] <= dm_wdata;
      if (dm_re) dm_in <= mem[dm_addr];
      if (ctx_busy) n_busy <= n_busy + 1;
      if (dm_we) n_we <= n_we + 1;
      if (dm_re) n_re <= n_re + 1;
      if (ctx_done) n_done <= n_done + 1;
      if (ctx_busy && (ra_ctrl == 2'b11 || ra_ctrl == 2'b01)) n_bad <= n_bad + 1;
      run <= ctx_busy ? run + 1 : 0;
      if (ctx_done) done_at <= run + 1;
      if (dm_we_fc) begin
         fc_addr_q.push_back(dm_addr_fc);
         fc_data_q.push_back(dm_wdata_fc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_regs(input logic [7:0] v [8]);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         cpu_ctrl   = 2'b10;
         cpu_rn_sel = i[2:0];
         cpu_s8     = 3'b001;
         alu        = v[i];
      end
      @(negedge clk);
      cpu_ctrl = 2'b00;
   endtask

   task automatic start_op(input logic s, input logic r, input logic fc);
      @(negedge clk);
      save_req    = s;
      restore_req = r;
      save_fc     = fc;
      @(negedge clk);
      save_req    = 1'b0;
      restore_req = 1'b0;
      save_fc     = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (ctx_busy === 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_idle_timeout"}, {31'd0, ctx_busy}, 32'd0);
   endtask

   task automatic rand_vals(output logic [7:0] v [8]);
      for (int i = 0; i < 8; i++) v[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic chk_window(input string tag, input logic [7:0] v [8]);
      logic [7:0] a;
      for (int i = 0; i < 8; i++) begin
         a = 8'hF0 + 8'(i);
         chk(tag, {24'd0, mem[a]}, {24'd0, v[i]});
      end
   endtask

   task automatic chk_regs(input string tag, input logic [7:0] v [8]);
      for (int i = 0; i < 8; i++) chk(tag, {24'd0, regs[i]}, {24'd0, v[i]});
   endtask

   initial begin
      logic [7:0] v [8];
      logic [7:0] w [8];
      logic [7:0] a;
      int b0, we0, re0, d0, bad0;

      rst = 1'b1; save_req = 1'b0; restore_req = 1'b0; save_fc = 1'b0; zero_fc = 1'b0;
      cpu_rn_sel = 3'd5; cpu_ctrl = 2'b11; cpu_s8 = 3'b011; alu = 8'h00;

      // Reset behaviour
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ra_ctrl", {30'd0, ra_ctrl}, 32'd0);
      chk("rst_rn_sel_follow", {29'd0, ra_rn_sel}, 32'd5);
      chk("rst_s8_follow", {29'd0, ra_s8}, 32'd3);
      chk("rst_busy", {29'd0, ctx_busy, ctx_done, cpu_stall}, 32'd0);
      chk("rst_dm", {22'd0, dm_we, dm_re, dm_addr}, 32'd0);
      cpu_ctrl = 2'b00;
      @(negedge clk);
      rst = 1'b0;

      // IDLE pass-through: ALU -> R0
      @(negedge clk);
      cpu_ctrl = 2'b01; cpu_s8 = 3'b001; alu = 8'h5A; cpu_rn_sel = 3'd2;
      #1;
      chk("pass_ctrl", {30'd0, ra_ctrl}, 32'd1);
      chk("pass_s8", {29'd0, ra_s8}, 32'd1);
      chk("pass_rn_sel", {29'd0, ra_rn_sel}, 32'd2);
      chk("idle_dm", {22'd0, dm_we, dm_re, dm_addr}, 32'd0);
      @(negedge clk);
      cpu_ctrl = 2'b00;
      chk("pass_r0", {24'd0, regs[0]}, 32'h5A);

      // Save 00..07 to F0..F7, with the FC-based instance saving alongside
      for (int i = 0; i < 8; i++) v[i] = 8'(i);
      load_regs(v);
      b0 = n_busy; we0 = n_we; d0 = n_done;
      start_op(1'b1, 1'b0, 1'b1);
      wait_idle("save0");
      chk_window("save0_dm", v);
      chk("save0_we_cycles", n_we - we0, 32'd8);
      chk("save0_busy_cycles", n_busy - b0, 32'd9);
      chk("save0_done_count", n_done - d0, 32'd1);
      chk("save0_done_pos", done_at, 32'd9);

      // Wrapped window ordering from the FC instance
      chk("fc_count", fc_addr_q.size(), 32'd8);
      for (int i = 0; i < 8; i++) begin
         a = 8'hFC + 8'(i);
         if (i < fc_addr_q.size()) begin
            chk("fc_addr", {24'd0, fc_addr_q[i]}, {24'd0, a});
            chk("fc_data", {24'd0, fc_data_q[i]}, {24'd0, v[i]});
         end
      end

      // Restore A0..A7 from the window
      for (int i = 0; i < 8; i++) v[i] = 8'hA0 + 8'(i);
      load_regs(v);
      start_op(1'b1, 1'b0, 1'b0);
      wait_idle("pre_restore");
      rand_vals(w);
      load_regs(w);
      b0 = n_busy; bad0 = n_bad; d0 = n_done;
      start_op(1'b0, 1'b1, 1'b0);
      wait_idle("restore0");
      chk_regs("restore0_regs", v);
      chk("restore0_r0_out", {24'd0, regs[0]}, 32'hA0);
      chk("restore0_busy_cycles", n_busy - b0, 32'd10);
      chk("restore0_bad_ctrl", n_bad - bad0, 32'd0);
      chk("restore0_done_pos", done_at, 32'd10);
      chk("restore0_done_count", n_done - d0, 32'd1);

      // Simultaneous requests, late restore request and broadcast attempt while busy
      rand_vals(v);
      load_regs(v);
      re0 = n_re; bad0 = n_bad;
      start_op(1'b1, 1'b1, 1'b0);
      restore_req = 1'b1; cpu_ctrl = 2'b11; cpu_s8 = 3'b001; alu = 8'($urandom_range(0, 255));
      #1;
      chk("busy_stall", {31'd0, cpu_stall}, 32'd1);
      chk("busy_ctrl_blocked", {30'd0, ra_ctrl}, 32'd0);
      repeat (3) @(negedge clk);
      restore_req = 1'b0; cpu_ctrl = 2'b00;
      wait_idle("both");
      repeat (4) @(negedge clk);
      chk_window("both_dm", v);
      chk_regs("both_regs_kept", v);
      chk("both_no_restore", n_re - re0, 32'd0);
      chk("both_bad_ctrl", n_bad - bad0, 32'd0);

      // Reset in the SAVE cycle with cnt = 4
      for (int i = 0; i < 8; i++) w[i] = v[i] ^ 8'($urandom_range(1, 255));
      load_regs(w);
      we0 = n_we; d0 = n_done;
      start_op(1'b1, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      #1;
      chk("midrst_addr", {24'd0, dm_addr}, 32'hF4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, ctx_busy}, 32'd0);
      chk("midrst_we", {31'd0, dm_we}, 32'd0);
      repeat (4) @(negedge clk);
      chk("midrst_we_cycles", n_we - we0, 32'd5);
      chk("midrst_no_done", n_done - d0, 32'd0);
      for (int i = 0; i < 8; i++) begin
         a = 8'hF0 + 8'(i);
         chk("midrst_dm", {24'd0, mem[a]}, {24'd0, (i <= 4) ? w[i] : v[i]});
      end

      // Randomized save / scramble / restore rounds
      for (int r = 0; r < 4; r++) begin
         rand_vals(v);
         load_regs(v);
         start_op(1'b1, 1'b0, 1'b0);
         wait_idle("rnd_save");
         chk_window("rnd_save_dm", v);
         rand_vals(w);
         load_regs(w);
         b0 = n_busy;
         start_op(1'b0, 1'b1, 1'b0);
         wait_idle("rnd_restore");
         chk_regs("rnd_restore_regs", v);
         chk("rnd_restore_busy", n_busy - b0, 32'd10);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
